// File: rtl/aes_encrypt_iter.sv
// Iterative FIPS-197 AES encryptor, one round per clock, NK/NR parameterised.
// Define AES_ENC_KEY_REG_EN to capture the cipher key at the start edge.

package aes_enc_pkg;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // GF(2^8) inverse as a^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] a2, a3, a12, a15, e, inv;
    a2  = gmul(a, a);
    a3  = gmul(a2, a);
    a12 = gmul(a3, a3);
    a12 = gmul(a12, a12);
    a15 = gmul(a12, a3);
    e   = a15;
    for (int i = 0; i < 4; i++) e = gmul(e, e);
    inv = gmul(gmul(e, a12), a2);
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(
    input int j
  );
    logic [7:0] x;
    x = 8'h01;
    for (int k = 1; k < j; k++) x = xtime(x);
    return x;
  endfunction

  function automatic logic [127:0] sub_shift(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] =
          sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(
    input logic [31:0] c
  );
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {
      xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
      b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
      b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
      xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)
    };
  endfunction

  function automatic logic [127:0] mix_cols(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

endpackage

module keyExpansion #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic [NK*32-1:0]      key_i,
  output logic [(NR+1)*128-1:0] w_o
);
  import aes_enc_pkg::*;

  localparam int NW = 4 * (NR + 1);

  always_comb begin
    logic [31:0] wd [NW];
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < NW; i++) wd[i] = '0;
    for (int i = 0; i < NK; i++) begin
      wd[i] = key_i[32*(NK-1-i) +: 32];
    end
    for (int i = NK; i < NW; i++) begin
      t = wd[i-1];
      if (i % NK == 0) begin
        t = sub_word({t[23:0], t[31:24]})
          ^ {rcon(i / NK), 24'h0};
      end else if (NK > 6 && i % NK == 4) begin
        t = sub_word(t);
      end
      wd[i] = wd[i-NK] ^ t;
    end
    // Round key r: words 4r..4r+3, word 4r in the MSBs.
    w_o = '0;
    for (int r = 0; r <= NR; r++) begin
      w_o[r*128 +: 128] =
        {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
    end
  end

endmodule

module aes_encrypt_iter #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NK*32-1:0] key,
  input  logic [127:0]     plaintext,
  output logic             busy,
  output logic             done,
  output logic [127:0]     ciphertext
);
  import aes_enc_pkg::*;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } state_e;

  localparam logic [3:0] RLAST = 4'(NR - 1);

  state_e                fsm_q;
  logic [3:0]            rnd_q;
  logic [127:0]          state_q;
  logic [127:0]          ct_q;
  logic                  done_q;
  logic [NK*32-1:0]      kx_key;
  logic [(NR+1)*128-1:0] w;
  logic [127:0]          rk0;
  logic [127:0]          rk_cur;
  logic [127:0]          rk_last;
  logic [127:0]          sr;
  logic [127:0]          rnd_out;
  logic [127:0]          last_out;

`ifdef AES_ENC_KEY_REG_EN
  logic [NK*32-1:0] key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
    end else if (fsm_q == IDLE && start) begin
      key_q <= key;
    end
  end

  // Raw key while idle so round 0 is ready at the start edge.
  assign kx_key = (fsm_q == IDLE) ? key : key_q;
`else
  assign kx_key = key;
`endif

  keyExpansion #(NK, NR) u_kx (
    .key_i (kx_key),
    .w_o   (w)
  );

  assign rk0     = w[127:0];
  assign rk_last = w[NR*128 +: 128];

  always_comb begin
    rk_cur = '0;
    for (int r = 1; r < NR; r++) begin
      if (rnd_q == r[3:0]) rk_cur = w[r*128 +: 128];
    end
  end

  assign sr       = sub_shift(state_q);
  assign rnd_out  = mix_cols(sr) ^ rk_cur;
  assign last_out = sr ^ rk_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= plaintext ^ rk0;
            rnd_q   <= 4'd1;
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          state_q <= rnd_out;
          rnd_q   <= rnd_q + 4'd1;
          if (rnd_q == RLAST) fsm_q <= FINAL;
        end
        FINAL: begin
          ct_q   <= last_out;
          done_q <= 1'b1;
          rnd_q  <= '0;
          fsm_q  <= IDLE;
        end
        default: begin
          rnd_q <= '0;
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (fsm_q != IDLE);
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Scoreboard bench for aes_encrypt_iter: known vectors, back-to-back,
// mid-block reset and random blocks against a byte-level AES model.
`timescale 1ns/1ps

module tb_aes_encrypt_iter;

  localparam int NK = 4;
  localparam int NR = NK + 6;
  localparam int KW = NK * 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] key = '0;
  logic [127:0]  plaintext = '0;
  logic          busy;
  logic          done;
  logic [127:0]  ciphertext;

  aes_encrypt_iter #(.NK(NK), .NR(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key        (key),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0]  ct;
    logic [127:0]  pt;
    logic [KW-1:0] k;
    int            at;
  } exp_t;

  exp_t sb[$];

  logic [7:0] sbt [256];
  logic [7:0] isbt [256];

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int i = 0; i < 8; i++)
        s[i] = s[i] ^ inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
             ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      sbt[x] = s;
      isbt[s] = 8'(x);
    end
  endtask

  // Round key r lives at ks[1919-128*r -: 128].
  function automatic logic [1919:0] ksched(input logic [KW-1:0] k);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] o;
    rc = 8'h01;
    o  = '0;
    for (int i = 0; i < 4 * (NR + 1); i++) begin
      if (i < NK) begin
        w[i] = k[KW-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % NK == 0) begin
          t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]}
            ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (NK == 8 && i % NK == 4) begin
          t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
        end
        w[i] = w[i-NK] ^ t;
      end
      o[1919-32*i -: 32] = w[i];
    end
    return o;
  endfunction

  function automatic logic [127:0] enc(input logic [KW-1:0] k,
                                       input logic [127:0] p);
    logic [1919:0] ks;
    logic [7:0]    a [16];
    logic [7:0]    b [16];
    logic [127:0]  o;
    ks = ksched(k);
    for (int i = 0; i < 16; i++)
      a[i] = p[127-8*i -: 8] ^ ks[1919-8*i -: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          b[q+4*c] = sbt[a[q+4*((c+q)%4)]];
      if (r < NR) begin
        for (int c = 0; c < 4; c++) begin
          int j;
          j = 4 * c;
          a[j]   = gm(8'h02, b[j]) ^ gm(8'h03, b[j+1]) ^ b[j+2] ^ b[j+3];
          a[j+1] = b[j] ^ gm(8'h02, b[j+1]) ^ gm(8'h03, b[j+2]) ^ b[j+3];
          a[j+2] = b[j] ^ b[j+1] ^ gm(8'h02, b[j+2]) ^ gm(8'h03, b[j+3]);
          a[j+3] = gm(8'h03, b[j]) ^ b[j+1] ^ b[j+2] ^ gm(8'h02, b[j+3]);
        end
      end else begin
        a = b;
      end
      for (int i = 0; i < 16; i++)
        a[i] = a[i] ^ ks[1919-128*r-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o;
  endfunction

  function automatic logic [127:0] dec(input logic [KW-1:0] k,
                                       input logic [127:0] ct);
    logic [1919:0] ks;
    logic [7:0]    a [16];
    logic [7:0]    b [16];
    logic [127:0]  o;
    ks = ksched(k);
    for (int i = 0; i < 16; i++)
      a[i] = ct[127-8*i -: 8] ^ ks[1919-128*NR-8*i -: 8];
    for (int r = NR - 1; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          b[q+4*c] = isbt[a[q+4*((c-q+4)%4)]];
      for (int i = 0; i < 16; i++)
        b[i] = b[i] ^ ks[1919-128*r-8*i -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          int j;
          j = 4 * c;
          a[j]   = gm(8'h0e, b[j]) ^ gm(8'h0b, b[j+1])
                 ^ gm(8'h0d, b[j+2]) ^ gm(8'h09, b[j+3]);
          a[j+1] = gm(8'h09, b[j]) ^ gm(8'h0e, b[j+1])
                 ^ gm(8'h0b, b[j+2]) ^ gm(8'h0d, b[j+3]);
          a[j+2] = gm(8'h0d, b[j]) ^ gm(8'h09, b[j+1])
                 ^ gm(8'h0e, b[j+2]) ^ gm(8'h0b, b[j+3]);
          a[j+3] = gm(8'h0b, b[j]) ^ gm(8'h0d, b[j+1])
                 ^ gm(8'h09, b[j+2]) ^ gm(8'h0e, b[j+3]);
        end
      end else begin
        a = b;
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  exp_t me;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done actual=%h required=no done",
                 ciphertext);
      end else begin
        me = sb.pop_front();
        check("ciphertext", ciphertext, me.ct);
        check("latency", 128'(cyc), 128'(me.at));
        check("busy_in_done", 128'(busy), 128'(0));
        check("loopback", dec(me.k, ciphertext), me.pt);
      end
    end
  end

  task automatic push_exp(input logic [KW-1:0] k,
                          input logic [127:0] p,
                          input logic [127:0] ct);
    exp_t e;
    e.ct = ct;
    e.pt = p;
    e.k  = k;
    e.at = cyc + 1 + NR;
    sb.push_back(e);
  endtask

  task automatic launch(input logic [KW-1:0] k,
                        input logic [127:0] p,
                        input logic [127:0] ct);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < NR + 5) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("launch_timeout", 128'(busy), 128'(0));
    key       = k;
    plaintext = p;
    start     = 1'b1;
    push_exp(k, p, ct);
    @(negedge clk);
    start = 1'b0;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 4 * NR + 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  function automatic logic [KW-1:0] seq_key();
    logic [KW-1:0] k;
    for (int i = 0; i < NK * 4; i++) k[KW-1-8*i -: 8] = 8'(i);
    return k;
  endfunction

  function automatic logic [127:0] kat_ct();
    case (NK)
      6:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      8:       return 128'h8ea2b7ca516745bfeafc49904b496089;
      default: return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    endcase
  endfunction

  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [KW-1:0]  k1, k2, kr;
    logic [255:0]   wide;
    logic [127:0]   p1, p2, pr, e1;
    int             n;

    build_tables();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_ct", ciphertext, 128'(0));
    rst_n = 1'b1;

    // Known-answer vector with latency check.
    launch(seq_key(), KAT_PT, kat_ct());
    drain();

    // Back-to-back with start held high across the done cycle.
    wide = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k1   = wide[255 -: KW];
    p1   = 128'h3243f6a8885a308d313198a2e0370734;
    e1   = (NK == 4) ? 128'h3925841d02dc09fbdc118597196a0b32
                     : enc(k1, p1);
    k2   = seq_key();
    p2   = KAT_PT;
    @(negedge clk);
    key       = k1;
    plaintext = p1;
    start     = 1'b1;
    push_exp(k1, p1, e1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) plaintext = {$urandom, $urandom, $urandom, $urandom};
    end while (!done && n < NR + 5);
    check("b2b_done1_seen", 128'(done), 128'(1));
    key       = k2;
    plaintext = p2;
    push_exp(k2, p2, kat_ct());
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of a block.
    launch(seq_key(), KAT_PT, kat_ct());
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_done", 128'(done), 128'(0));
    check("midrst_ct", ciphertext, 128'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (NR + 5) @(negedge clk);
    check("midrst_ct_hold", ciphertext, 128'(0));
    launch(seq_key(), KAT_PT, kat_ct());
    drain();

`ifdef AES_ENC_KEY_REG_EN
    // Key may change once the block is in flight.
    launch(seq_key(), KAT_PT, kat_ct());
    key = '1;
    drain();
`endif

    // Random blocks against the model, with decrypt loop-back.
    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < NK; i++) kr[32*i +: 32] = $urandom;
      pr = {$urandom, $urandom, $urandom, $urandom};
      launch(kr, pr, enc(kr, pr));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
